// File: rtl/decode_queue_ctrl.sv
// Decode-to-rename decoupling queue: a small FIFO of decoded bundles with
// valid/ready on both sides, a synchronous flush and an occupancy count.
module decode_queue_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PC_W-1:0]              in_pc,
  input  logic [31:0]                  in_instr,
  input  logic [6:0]                   in_c_sig,
  input  logic [2:0]                   in_alu_sig,
  input  logic [31:0]                  in_imm,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              out_pc,
  output logic [31:0]                  out_instr,
  output logic [6:0]                   out_c_sig,
  output logic [2:0]                   out_alu_sig,
  output logic [31:0]                  out_imm,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         illegal
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {StEmpty, StActive, StFull} state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic [6:0]      c_sig;
    logic [2:0]      alu_sig;
    logic [31:0]     imm;
  } bundle_t;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  bundle_t       mem_q [DEPTH];
  bundle_t       mem_d [DEPTH];
  bundle_t       head;
  logic          push, pop;

  // in_ready ignores out_ready, so a full queue refuses pushes even while popping.
  assign in_ready  = !rst && (state_q != StFull) && !flush;
  assign out_valid = (state_q != StEmpty) && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Head fields are forced to zero whenever no valid head is presented.
  always_comb begin
    head = '0;
    if (out_valid) begin
      head = mem_q[rd_ptr_q];
    end
    out_pc      = head.pc;
    out_instr   = head.instr;
    out_c_sig   = head.c_sig;
    out_alu_sig = head.alu_sig;
    out_imm     = head.imm;
    illegal     = out_valid && (head.c_sig == 7'd0) && (head.instr != 32'd0);
  end

  // Next-state: storage write, pointer/count update, state derived from next count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = StEmpty;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: in_pc, instr: in_instr, c_sig: in_c_sig,
                            alu_sig: in_alu_sig, imm: in_imm};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      if (count_d == '0) begin
        state_d = StEmpty;
      end else if (count_d == CW'(DEPTH)) begin
        state_d = StFull;
      end else begin
        state_d = StActive;
      end
    end
  end

  // State register; reset drops every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StEmpty;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_decode_queue_ctrl.sv
// Directed bench for decode_queue_ctrl with hand-computed expectations.
module tb_decode_queue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_pc;
  logic [31:0] in_instr;
  logic [6:0]  in_c_sig;
  logic [2:0]  in_alu_sig;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_pc;
  logic [31:0] out_instr;
  logic [6:0]  out_c_sig;
  logic [2:0]  out_alu_sig;
  logic [31:0] out_imm;
  logic [2:0]  count;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  decode_queue_ctrl #(.DEPTH(4), .PC_W(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .in_c_sig    (in_c_sig),
    .in_alu_sig  (in_alu_sig),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_c_sig   (out_c_sig),
    .out_alu_sig (out_alu_sig),
    .out_imm     (out_imm),
    .count       (count),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] pc, input logic [31:0] instr,
                       input logic [6:0] c, input logic [2:0] alu, input logic [31:0] imm);
    in_valid   = v;
    in_pc      = pc;
    in_instr   = instr;
    in_c_sig   = c;
    in_alu_sig = alu;
    in_imm     = imm;
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 12'h0, 32'h0, 7'h0, 3'h0, 32'h0);
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_out_pc", out_pc, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // T2: single push, one cycle latency, no bypass.
    drive(1'b1, 12'h004, 32'h00500093, 7'h13, 3'b000, 32'd5);
    check("t2_no_bypass", out_valid, 0);
    step();
    drive(1'b0, 12'h0, 32'h0, 7'h0, 3'h0, 32'h0);
    check("t2_out_valid", out_valid, 1);
    check("t2_out_pc", out_pc, 12'h004);
    check("t2_out_instr", out_instr, 32'h00500093);
    check("t2_out_alu", out_alu_sig, 0);
    check("t2_out_imm", out_imm, 5);
    check("t2_count", count, 1);
    check("t2_illegal", illegal, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    check("t2_empty_count", count, 0);
    check("t2_empty_valid", out_valid, 0);
    check("t2_empty_pc", out_pc, 0);

    // T3: fill to full, fifth offer held, then ordered drain.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 12'(4 * i), 32'(i + 1), 7'h1, 3'(i), 32'(i));
      step();
    end
    drive(1'b1, 12'h010, 32'h55, 7'h1, 3'h5, 32'h10);
    check("t3_full_count", count, 4);
    check("t3_full_in_ready", in_ready, 0);
    step();
    check("t3_held_count", count, 4);
    out_ready = 1'b1;
    #1;
    check("t3_full_pop_in_ready", in_ready, 0);
    check("t3_pop0_pc", out_pc, 12'h000);
    step();
    out_ready = 1'b0;
    #1;
    check("t3_after_pop_count", count, 3);
    check("t3_reopen_in_ready", in_ready, 1);
    step();
    drive(1'b0, 12'h0, 32'h0, 7'h0, 3'h0, 32'h0);
    check("t3_refill_count", count, 4);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("t3_order_pc", out_pc, 12'(4 * i));
      step();
    end
    out_ready = 1'b0;
    #1;
    check("t3_drained_count", count, 0);

    // T4: steady push+pop at count=2; pointers wrap several times.
    drive(1'b1, 12'h100, 32'h1, 7'h1, 3'h0, 32'h0);
    step();
    drive(1'b1, 12'h104, 32'h1, 7'h1, 3'h0, 32'h0);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 12'(12'h108 + 4 * i), 32'h1, 7'h1, 3'h0, 32'h0);
      check("t4_count", count, 2);
      check("t4_order_pc", out_pc, 12'(12'h100 + 4 * i));
      step();
    end
    out_ready = 1'b0;
    drive(1'b1, 12'h130, 32'h1, 7'h1, 3'h0, 32'h0);
    check("t4_end_count", count, 2);
    check("t4_end_pc", out_pc, 12'h128);
    step();

    // T5: flush at count=3 with both sides willing.
    check("t5_pre_count", count, 3);
    flush     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 12'h200, 32'h1, 7'h1, 3'h0, 32'h0);
    check("t5_flush_in_ready", in_ready, 0);
    check("t5_flush_out_valid", out_valid, 0);
    check("t5_flush_out_pc", out_pc, 0);
    step();
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 12'h0, 32'h0, 7'h0, 3'h0, 32'h0);
    check("t5_count", count, 0);
    check("t5_out_valid", out_valid, 0);
    check("t5_in_ready", in_ready, 1);

    // T6: illegal indication for c_sig==0 with nonzero instr only.
    check("t6_empty_illegal", illegal, 0);
    drive(1'b1, 12'h300, 32'h0000007F, 7'h0, 3'h0, 32'h0);
    step();
    drive(1'b1, 12'h304, 32'h00000000, 7'h0, 3'h0, 32'h0);
    step();
    drive(1'b0, 12'h0, 32'h0, 7'h0, 3'h0, 32'h0);
    check("t6_illegal", illegal, 1);
    check("t6_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    check("t6_zero_instr_illegal", illegal, 0);
    check("t6_zero_instr_pc", out_pc, 12'h304);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // T1: asynchronous reset mid-cycle with count=3.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 12'(12'h400 + 4 * i), 32'h1, 7'h1, 3'h0, 32'h0);
      step();
    end
    drive(1'b0, 12'h0, 32'h0, 7'h0, 3'h0, 32'h0);
    check("t1_pre_count", count, 3);
    #2;
    rst = 1'b1;
    #1;
    check("t1_async_count", count, 0);
    check("t1_async_out_valid", out_valid, 0);
    check("t1_async_in_ready", in_ready, 0);
    check("t1_async_out_pc", out_pc, 0);
    step();
    rst = 1'b0;
    step();
    check("t1_release_in_ready", in_ready, 1);
    check("t1_release_count", count, 0);
    check("t1_release_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
